// File: rtl/axi_lite_arbiter_2to1_if.sv
// User-side AXI4-lite request/response bundle.
// The "master" modport issues requests (requester, or arbiter toward the bus).
// The "slave" modport serves them (arbiter toward a requester, or the bus master).
interface axi_lite_arbiter_2to1_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
);

  // write request and completion
  logic                          w_valid;
  logic [AXI_ADDR_WIDTH-1:0]     w_addr;
  logic [AXI_DATA_WIDTH-1:0]     w_data;
  logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
  logic                          w_ready;

  // read request and data return
  logic                          r_ready;
  logic [AXI_ADDR_WIDTH-1:0]     r_addr;
  logic                          r_valid;
  logic [AXI_DATA_WIDTH-1:0]     r_data;

  modport master (
    output w_valid, w_addr, w_data, w_strb,
    input  w_ready,
    output r_ready, r_addr,
    input  r_valid, r_data
  );

  modport slave (
    input  w_valid, w_addr, w_data, w_strb,
    output w_ready,
    input  r_ready, r_addr,
    output r_valid, r_data
  );

endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-requester round-robin arbiter in front of one AXI4-lite user-side
// bus master. One transaction in flight; request fields are captured at
// grant so the bus master sees them stable until completion.
module axi_lite_arbiter_2to1 #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                   AXI_ACLK,
  input  logic                   AXI_ARESET,
  axi_lite_arbiter_2to1_if.slave  s0,
  axi_lite_arbiter_2to1_if.slave  s1,
  axi_lite_arbiter_2to1_if.master m,
  output logic                   busy,
  output logic                   grant
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_W = 2'd1,
    BUSY_R = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rr_ptr;
  logic grant_q;
  logic busy_q;

  logic pend0;
  logic pend1;
  logic sel;
  logic sel_write;
  logic take_w;
  logic take_r;
  logic done;

  logic [AXI_ADDR_WIDTH-1:0] req_w_addr;
  logic [AXI_DATA_WIDTH-1:0] req_w_data;
  logic [STRB_W-1:0]         req_w_strb;
  logic [AXI_ADDR_WIDTH-1:0] req_r_addr;

  logic                      m_w_valid_q;
  logic [AXI_ADDR_WIDTH-1:0] m_w_addr_q;
  logic [AXI_DATA_WIDTH-1:0] m_w_data_q;
  logic [STRB_W-1:0]         m_w_strb_q;
  logic                      m_r_ready_q;
  logic [AXI_ADDR_WIDTH-1:0] m_r_addr_q;

  logic w_done;
  logic r_done;

  // A requester is pending on either request level; its write wins over its read.
  assign pend0 = s0.w_valid | s0.r_ready;
  assign pend1 = s1.w_valid | s1.r_ready;

  // Pick the requester to serve: sole pending one, otherwise the round-robin pointer.
  always_comb begin
    sel        = 1'b0;
    if (pend0 && pend1) begin
      sel = rr_ptr;
    end else if (pend1) begin
      sel = 1'b1;
    end
    sel_write  = sel ? s1.w_valid : s0.w_valid;
    req_w_addr = sel ? s1.w_addr  : s0.w_addr;
    req_w_data = sel ? s1.w_data  : s0.w_data;
    req_w_strb = sel ? s1.w_strb  : s0.w_strb;
    req_r_addr = sel ? s1.r_addr  : s0.r_addr;
  end

  // Next-state decode: grant from IDLE, complete on the matching bus response only.
  always_comb begin
    state_nxt = state;
    take_w    = 1'b0;
    take_r    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          if (sel_write) begin
            state_nxt = BUSY_W;
            take_w    = 1'b1;
          end else begin
            state_nxt = BUSY_R;
            take_r    = 1'b1;
          end
        end
      end
      BUSY_W: begin
        if (m.w_ready) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      BUSY_R: begin
        if (m.r_valid) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ownership tracking: grant index, busy flag and round-robin pointer.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      rr_ptr  <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (take_w || take_r) begin
      grant_q <= sel;
      busy_q  <= 1'b1;
    end else if (done) begin
      busy_q  <= 1'b0;
      rr_ptr  <= ~grant_q;
    end
  end

  // Bus-side write request: fields captured at grant, valid dropped on completion.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      m_w_valid_q <= 1'b0;
      m_w_addr_q  <= '0;
      m_w_data_q  <= '0;
      m_w_strb_q  <= '0;
    end else if (take_w) begin
      m_w_valid_q <= 1'b1;
      m_w_addr_q  <= req_w_addr;
      m_w_data_q  <= req_w_data;
      m_w_strb_q  <= req_w_strb;
    end else if (done) begin
      m_w_valid_q <= 1'b0;
    end
  end

  // Bus-side read request: address captured at grant, request dropped on completion.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      m_r_ready_q <= 1'b0;
      m_r_addr_q  <= '0;
    end else if (take_r) begin
      m_r_ready_q <= 1'b1;
      m_r_addr_q  <= req_r_addr;
    end else if (done) begin
      m_r_ready_q <= 1'b0;
    end
  end

  assign m.w_valid = m_w_valid_q;
  assign m.w_addr  = m_w_addr_q;
  assign m.w_data  = m_w_data_q;
  assign m.w_strb  = m_w_strb_q;
  assign m.r_ready = m_r_ready_q;
  assign m.r_addr  = m_r_addr_q;

  // Responses are only forwarded when they match the transaction in flight.
  assign w_done = (state == BUSY_W) && m.w_ready;
  assign r_done = (state == BUSY_R) && m.r_valid;

  assign s0.w_ready = w_done && !grant_q;
  assign s1.w_ready = w_done &&  grant_q;
  assign s0.r_valid = r_done && !grant_q;
  assign s1.r_valid = r_done &&  grant_q;

  // Read data is a straight fan-out; qualified by each requester's r_valid.
  assign s0.r_data = m.r_data;
  assign s1.r_data = m.r_data;

  assign busy  = busy_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for the 2:1 AXI4-lite arbiter: table of single transactions plus
// hand-written contention, priority, stability and reset sequences.
module tb_axi_lite_arbiter_2to1;

  localparam int DW = 64;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter_2to1_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) s0_if ();
  axi_lite_arbiter_2to1_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) s1_if ();
  axi_lite_arbiter_2to1_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) m_if ();

  axi_lite_arbiter_2to1 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .AXI_ACLK   (clk),
    .AXI_ARESET (rst),
    .s0         (s0_if),
    .s1         (s1_if),
    .m          (m_if),
    .busy       (busy),
    .grant      (grant)
  );

  typedef struct {
    logic          who;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    strb;
    int            lat;
    logic          e_grant;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [7:0]    e_strb;
  } vec_t;

  typedef struct {
    logic          g;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    strb;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic who, input logic wv, input logic rr,
                         input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                         input logic [7:0] wstrb, input logic [AW-1:0] raddr);
    if (!who) begin
      s0_if.w_valid = wv; s0_if.w_addr = waddr; s0_if.w_data = wdata;
      s0_if.w_strb = wstrb; s0_if.r_ready = rr; s0_if.r_addr = raddr;
    end else begin
      s1_if.w_valid = wv; s1_if.w_addr = waddr; s1_if.w_data = wdata;
      s1_if.w_strb = wstrb; s1_if.r_ready = rr; s1_if.r_addr = raddr;
    end
  endtask

  function automatic logic wrdy(input logic who);
    return who ? s1_if.w_ready : s0_if.w_ready;
  endfunction

  function automatic logic rvld(input logic who);
    return who ? s1_if.r_valid : s0_if.r_valid;
  endfunction

  function automatic logic [DW-1:0] rdat(input logic who);
    return who ? s1_if.r_data : s0_if.r_data;
  endfunction

  // Wait (bounded) at negedges for the bus-side write or read request.
  task automatic wait_req(input logic is_w, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_w ? m_if.w_valid : m_if.r_ready) && cyc < 20);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mwv"},  64'(m_if.w_valid), 64'd0);
    check({tag, "_mrr"},  64'(m_if.r_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rsp"},  64'({s0_if.w_ready, s1_if.w_ready, s0_if.r_valid, s1_if.r_valid}), 64'd0);
  endtask

  initial begin
    int   cyc;
    exp_t e;

    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    m_if.w_ready = 1'b0;
    m_if.r_valid = 1'b0;
    m_if.r_data  = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 0,
                1'b0, 32'h8000_0000, 64'h1122_3344_5566_7788, 8'h00};
    vecs[0].data = 64'h1122_3344_5566_7788;
    vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1,
                1'b1, 32'h8000_1000, 64'h0000_0000_DEAD_BEEF, 8'h0F};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 2,
                1'b0, 32'h0000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_2000, 64'hCAFE_F00D_1234_5678, 8'h00, 0,
                1'b1, 32'h0000_2000, 64'hCAFE_F00D_1234_5678, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3,
                1'b0, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 64'h0000_0000_0000_0000, 8'h80, 0,
                1'b1, 32'h0000_0000, 64'h0000_0000_0000_0000, 8'h80};

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check("rst_mwv",   64'(m_if.w_valid), 64'd0);
    check("rst_mrr",   64'(m_if.r_ready), 64'd0);
    check("rst_maddr", 64'({m_if.w_addr, m_if.r_addr}), 64'd0);
    check("rst_mdata", 64'(m_if.w_data), 64'd0);
    check("rst_mstrb", 64'(m_if.w_strb), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Stray responses in IDLE must not reach a requester.
    m_if.w_ready = 1'b1;
    m_if.r_valid = 1'b1;
    #1;
    check("idle_stray_rsp", 64'({s0_if.w_ready, s1_if.w_ready, s0_if.r_valid, s1_if.r_valid}), 64'd0);
    @(negedge clk);
    m_if.w_ready = 1'b0;
    m_if.r_valid = 1'b0;
    check("idle_stray_busy", 64'(busy), 64'd0);

    // Table of single, uncontended transactions.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{vecs[i].e_grant, vecs[i].wr, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_strb});
      if (vecs[i].wr)
        set_req(vecs[i].who, 1'b1, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].strb, '0);
      else
        set_req(vecs[i].who, 1'b0, 1'b1, '0, '0, '0, vecs[i].addr);
      wait_req(vecs[i].wr, cyc);
      e = exp_q.pop_front();
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd1);
      check($sformatf("v%0d_grant", i), 64'(grant), 64'(e.g));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      if (e.wr) begin
        check($sformatf("v%0d_waddr", i), 64'(m_if.w_addr), 64'(e.addr));
        check($sformatf("v%0d_wdata", i), m_if.w_data, e.data);
        check($sformatf("v%0d_wstrb", i), 64'(m_if.w_strb), 64'(e.strb));
        check($sformatf("v%0d_mrr", i), 64'(m_if.r_ready), 64'd0);
      end else begin
        check($sformatf("v%0d_raddr", i), 64'(m_if.r_addr), 64'(e.addr));
        check($sformatf("v%0d_mwv", i), 64'(m_if.w_valid), 64'd0);
      end
      repeat (vecs[i].lat) @(negedge clk);
      if (e.wr) begin
        m_if.w_ready = 1'b1;
      end else begin
        m_if.r_valid = 1'b1;
        m_if.r_data  = e.data;
      end
      #1;
      if (e.wr) begin
        check($sformatf("v%0d_own_wready", i), 64'(wrdy(e.g)), 64'd1);
        check($sformatf("v%0d_oth_wready", i), 64'(wrdy(~e.g)), 64'd0);
      end else begin
        check($sformatf("v%0d_own_rvalid", i), 64'(rvld(e.g)), 64'd1);
        check($sformatf("v%0d_oth_rvalid", i), 64'(rvld(~e.g)), 64'd0);
        check($sformatf("v%0d_rdata", i), rdat(e.g), e.data);
      end
      set_req(vecs[i].who, 1'b0, 1'b0, '0, '0, '0, '0);
      @(negedge clk);
      m_if.w_ready = 1'b0;
      m_if.r_valid = 1'b0;
      #1;
      check_idle_outputs($sformatf("v%0d_after", i));
    end

    // Contention from reset: grants alternate 0,1,0,1 with one IDLE cycle between.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b1, '0, '0, '0, 32'h0000_A000);
    set_req(1'b1, 1'b0, 1'b1, '0, '0, '0, 32'h0000_B000);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{k[0], 1'b0, (k[0] ? 32'h0000_B000 : 32'h0000_A000),
                        64'h0123_0000_0000_0000 + 64'(k), 8'h00});
    end
    for (int k = 0; k < 4; k++) begin
      wait_req(1'b0, cyc);
      e = exp_q.pop_front();
      check($sformatf("rr%0d_gap", k), 64'(cyc), 64'd1);
      check($sformatf("rr%0d_grant", k), 64'(grant), 64'(e.g));
      check($sformatf("rr%0d_raddr", k), 64'(m_if.r_addr), 64'(e.addr));
      m_if.r_valid = 1'b1;
      m_if.r_data  = e.data;
      #1;
      check($sformatf("rr%0d_own_rvalid", k), 64'(rvld(e.g)), 64'd1);
      check($sformatf("rr%0d_oth_rvalid", k), 64'(rvld(~e.g)), 64'd0);
      check($sformatf("rr%0d_rdata", k), rdat(e.g), e.data);
      @(negedge clk);
      m_if.r_valid = 1'b0;
      check($sformatf("rr%0d_turnaround", k), 64'(m_if.r_ready), 64'd0);
      check($sformatf("rr%0d_busy", k), 64'(busy), 64'd0);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    // Same requester: write served before read; mismatched response ignored.
    set_req(1'b0, 1'b1, 1'b1, 32'h0000_0300, 64'h0000_0000_0000_3333, 8'h3C, 32'h0000_0400);
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_0300, 64'h0000_0000_0000_3333, 8'h3C});
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_0400, 64'h0000_0000_0000_4444, 8'h00});
    wait_req(1'b1, cyc);
    e = exp_q.pop_front();
    check("pri_w_first", 64'(m_if.w_valid), 64'd1);
    check("pri_no_read", 64'(m_if.r_ready), 64'd0);
    check("pri_waddr", 64'(m_if.w_addr), 64'(e.addr));
    m_if.r_valid = 1'b1;
    #1;
    check("pri_stray_rvalid", 64'(s0_if.r_valid), 64'd0);
    check("pri_stray_wready", 64'(s0_if.w_ready), 64'd0);
    @(negedge clk);
    m_if.r_valid = 1'b0;
    check("pri_still_busy", 64'(busy), 64'd1);
    check("pri_still_mwv", 64'(m_if.w_valid), 64'd1);
    m_if.w_ready = 1'b1;
    #1;
    check("pri_wready", 64'(s0_if.w_ready), 64'd1);
    s0_if.w_valid = 1'b0;
    @(negedge clk);
    m_if.w_ready = 1'b0;
    wait_req(1'b0, cyc);
    e = exp_q.pop_front();
    check("pri_read_gap", 64'(cyc), 64'd1);
    check("pri_raddr", 64'(m_if.r_addr), 64'(e.addr));
    m_if.r_valid = 1'b1;
    m_if.r_data  = e.data;
    #1;
    check("pri_rvalid", 64'(s0_if.r_valid), 64'd1);
    check("pri_rdata", s0_if.r_data, e.data);
    s0_if.r_ready = 1'b0;
    @(negedge clk);
    m_if.r_valid = 1'b0;

    // Address change while owning the bus does not disturb the latched request.
    set_req(1'b0, 1'b0, 1'b1, '0, '0, '0, 32'h0000_0100);
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_0100, 64'h0000_0000_0000_0100, 8'h00});
    wait_req(1'b0, cyc);
    e = exp_q.pop_front();
    check("stab_raddr0", 64'(m_if.r_addr), 64'(e.addr));
    s0_if.r_addr = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stab_raddr%0d", k + 1), 64'(m_if.r_addr), 64'(e.addr));
    end
    m_if.r_valid = 1'b1;
    m_if.r_data  = e.data;
    #1;
    check("stab_rvalid", 64'(s0_if.r_valid), 64'd1);
    s0_if.r_ready = 1'b0;
    @(negedge clk);
    m_if.r_valid = 1'b0;

    // Asynchronous reset in the middle of a write.
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_5000, 64'h5555_5555_5555_5555, 8'hFF, '0);
    wait_req(1'b1, cyc);
    check("ar_granted", 64'(m_if.w_valid), 64'd1);
    check("ar_grant1", 64'(grant), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_mwv", 64'(m_if.w_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_grant", 64'(grant), 64'd0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    m_if.w_ready = 1'b1;
    #1;
    check("ar_stray_wready", 64'({s0_if.w_ready, s1_if.w_ready}), 64'd0);
    @(negedge clk);
    m_if.w_ready = 1'b0;
    #1;
    check_idle_outputs("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
